// File: rtl/video2ram.sv
// video2ram: capture side of the line-buffer video path.
//
// Samples the Dreamcast digital video stream (24-bit RGB, active-low
// hsync/vsync), measures field geometry and writes the active picture into
// the shared 4-line x 1024-pixel dual-port line buffer. Once enough lines of
// a field are buffered, it raises starttrigger so the output side can start
// reading. It also publishes the detected source modes (240p line doubling,
// interlace add-line) to the output side.
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-low reset
//   pixel_en      qualifies indata/hsync_n/vsync_n on this clock
//   indata[23:0]  RGB sample, [23:16]=R [15:8]=G [7:0]=B
//   hsync_n       horizontal sync, active-low
//   vsync_n       vertical sync, active-low
//   wraddr[11:0]  line-buffer write address {line[1:0], pixel[9:0]}
//   wrdata[23:0]  line-buffer write data
//   wren          line-buffer write strobe (one clock per active sample)
//   starttrigger  sticky "buffer primed" flag for the output side
//   line_doubler  1 = 240p source
//   add_line      1 = interlaced source
//   field_lines   line count of the last complete field
//
// Build option:
//   VIDEO2RAM_TESTPATTERN_EN  replaces the written pixel data with eight
//                             80-pixel vertical colour bars (indata ignored).

module video2ram #(
  parameter logic [10:0] H_ACTIVE_START    = 11'd128,
  parameter logic [10:0] H_ACTIVE_WIDTH    = 11'd640,
  parameter logic [10:0] V_ACTIVE_START    = 11'd36,
  parameter logic [10:0] V_ACTIVE_LINES    = 11'd480,
  parameter logic [1:0]  TRIGGER_LINES     = 2'd2,
  parameter logic [10:0] DOUBLER_THRESHOLD = 11'd400
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixel_en,
  input  logic [23:0] indata,
  input  logic        hsync_n,
  input  logic        vsync_n,
  output logic [11:0] wraddr,
  output logic [23:0] wrdata,
  output logic        wren,
  output logic        starttrigger,
  output logic        line_doubler,
  output logic        add_line,
  output logic [10:0] field_lines
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t      state;

  // Input register stage and sync history
  logic [23:0] in_data;
  logic        in_hs;
  logic        in_vs;
  logic        prev_hs;
  logic        prev_vs;

  logic [10:0] hcount;
  logic [10:0] vcount;

  // Combinational next-position and decision logic
  logic        hs_fall;
  logic        vs_fall;
  logic [10:0] h_next;
  logic [10:0] v_next;
  logic [10:0] ly;
  logic [9:0]  px;
  logic        active;
  logic        sync_lost;
  logic [10:0] meas_lines;
  logic [10:0] line_diff;
  logic        new_doubler;
  logic        new_add_line;
  logic [23:0] pix_data;

  logic [11:0] h_end;
  logic [11:0] v_end;

  assign h_end = {1'b0, H_ACTIVE_START} + {1'b0, H_ACTIVE_WIDTH};
  assign v_end = {1'b0, V_ACTIVE_START} + {1'b0, V_ACTIVE_LINES};

`ifdef VIDEO2RAM_TESTPATTERN_EN
  // Bars are 80 pixels wide so that eight of them span a 640-pixel line.
  function automatic logic [23:0] bar_colour(input logic [9:0] p);
    if      (p < 10'd80)  return 24'hFFFFFF;  // white
    else if (p < 10'd160) return 24'hFFFF00;  // yellow
    else if (p < 10'd240) return 24'h00FFFF;  // cyan
    else if (p < 10'd320) return 24'h00FF00;  // green
    else if (p < 10'd400) return 24'hFF00FF;  // magenta
    else if (p < 10'd480) return 24'hFF0000;  // red
    else if (p < 10'd560) return 24'h0000FF;  // blue
    else                  return 24'h000000;  // black
  endfunction
`endif

  always_comb begin
    hs_fall = prev_hs & ~in_hs;
    vs_fall = prev_vs & ~in_vs;

    // Position of the sample currently held in the input register.
    // A vsync edge wins over a simultaneous hsync edge.
    h_next = hcount;
    v_next = vcount;
    if (vs_fall) begin
      h_next = '0;
      v_next = '0;
    end else if (hs_fall) begin
      h_next = '0;
      v_next = (vcount == '1) ? vcount : vcount + 11'd1;
    end else begin
      h_next = (hcount == '1) ? hcount : hcount + 11'd1;
    end

    ly = v_next - V_ACTIVE_START;
    px = h_next[9:0] - H_ACTIVE_START[9:0];

    active = ({1'b0, v_next} >= {1'b0, V_ACTIVE_START}) && ({1'b0, v_next} < v_end) &&
             ({1'b0, h_next} >= {1'b0, H_ACTIVE_START}) && ({1'b0, h_next} < h_end);

    sync_lost = (v_next == '1);

    // vcount at the vsync edge counts hsync edges since the previous vsync,
    // which is one less than the number of lines in the field.
    meas_lines   = vcount + 11'd1;
    line_diff    = (meas_lines > field_lines) ? (meas_lines - field_lines)
                                              : (field_lines - meas_lines);
    new_doubler  = (meas_lines < DOUBLER_THRESHOLD);
    new_add_line = (line_diff == 11'd1);

`ifdef VIDEO2RAM_TESTPATTERN_EN
    pix_data = bar_colour(px);
`else
    pix_data = in_data;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      in_data      <= '0;
      in_hs        <= 1'b1;
      in_vs        <= 1'b1;
      prev_hs      <= 1'b1;
      prev_vs      <= 1'b1;
      hcount       <= '0;
      vcount       <= '0;
      wraddr       <= '0;
      wrdata       <= '0;
      wren         <= 1'b0;
      starttrigger <= 1'b0;
      line_doubler <= 1'b0;
      add_line     <= 1'b0;
      field_lines  <= '0;
    end else begin
      wren <= 1'b0;
      if (pixel_en) begin
        in_data <= indata;
        in_hs   <= hsync_n;
        in_vs   <= vsync_n;
        prev_hs <= in_hs;
        prev_vs <= in_vs;
        hcount  <= h_next;
        vcount  <= v_next;

        if (sync_lost) begin
          state        <= IDLE;
          starttrigger <= 1'b0;
          line_doubler <= 1'b0;
          add_line     <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              if (vs_fall) state <= MEASURE;
            end
            MEASURE: begin
              if (vs_fall) begin
                field_lines  <= meas_lines;
                line_doubler <= new_doubler;
                add_line     <= new_add_line;
                state        <= RUN;
              end
            end
            RUN: begin
              if (active) begin
                wren   <= 1'b1;
                wraddr <= {ly[1:0], px};
                wrdata <= pix_data;
                if (ly == {9'd0, TRIGGER_LINES}) starttrigger <= 1'b1;
              end
              // A mode change drops back to measuring; this overrides any
              // trigger set above in the same cycle.
              if (vs_fall) begin
                field_lines <= meas_lines;
                if ((new_doubler != line_doubler) || (new_add_line != add_line)) begin
                  line_doubler <= new_doubler;
                  add_line     <= new_add_line;
                  starttrigger <= 1'b0;
                  state        <= MEASURE;
                end
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_video2ram.sv
// Self-checking bench for video2ram. Uses a reduced video geometry
// (24-pixel lines, 12 active pixels from hcount 6, 20 active lines from
// vcount 3, 240p threshold 22 lines) so that complete fields and the
// 2100-line sync-loss hold stay short.

module tb_video2ram;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pixel_en = 1'b0;
  logic [23:0] indata = '0;
  logic        hsync_n = 1'b1;
  logic        vsync_n = 1'b1;
  logic [11:0] wraddr;
  logic [23:0] wrdata;
  logic        wren;
  logic        starttrigger;
  logic        line_doubler;
  logic        add_line;
  logic [10:0] field_lines;

  always #5 clock = ~clock;

  video2ram #(
    .H_ACTIVE_START   (11'd6),
    .H_ACTIVE_WIDTH   (11'd12),
    .V_ACTIVE_START   (11'd3),
    .V_ACTIVE_LINES   (11'd20),
    .TRIGGER_LINES    (2'd2),
    .DOUBLER_THRESHOLD(11'd22)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pixel_en    (pixel_en),
    .indata      (indata),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .wraddr      (wraddr),
    .wrdata      (wrdata),
    .wren        (wren),
    .starttrigger(starttrigger),
    .line_doubler(line_doubler),
    .add_line    (add_line),
    .field_lines (field_lines)
  );

  typedef struct {
    logic [23:0] data;
    logic [11:0] addr;
    int          cyc;
    int          lat;
  } exp_t;

  typedef struct {
    bit rst;
    int lines;
    int len;
    bit vs;
    bit tog;
    bit wr;
    int fl;
    bit ld_s, al_s, st_s;
    bit ld_e, al_e, st_e;
  } vec_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic pe_last = 1'b0;
  logic st_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (wren === 1'b1) begin
      check("wren_on_pixel_en", {31'd0, pe_last}, 32'd1);
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wren: wren=1 wraddr=%0h at cycle %0d, required no write", wraddr, cyc);
      end else begin
        e = q.pop_front();
        check("wraddr", {20'd0, wraddr}, {20'd0, e.addr});
        check("wrdata", {8'd0, wrdata}, {8'd0, e.data});
        check("latency", cyc - e.cyc, e.lat);
      end
    end
    if (starttrigger === 1'b1 && st_prev !== 1'b1) begin
      check("st_rise_wren", {31'd0, wren}, 32'd1);
      check("st_rise_addr", {20'd0, wraddr}, 32'h800);
    end
    st_prev = starttrigger;
  endtask

  task automatic step(input logic pe, input logic rst_n, input logic hs, input logic vs,
                      input logic [23:0] d, input logic exp_wr, input logic [11:0] a,
                      input int lat);
    @(negedge clock);
    cyc++;
    monitor();
    pe_last  = pe;
    reset    = rst_n;
    pixel_en = pe;
    hsync_n  = hs;
    vsync_n  = vs;
    indata   = d;
    if (exp_wr) q.push_back('{data: d, addr: a, cyc: cyc, lat: lat});
  endtask

  task automatic sample(input logic hs, input logic vs, input logic [23:0] d,
                        input logic exp_wr, input logic [11:0] a, input bit tog);
    logic [1:0] junk;
    if (tog) begin
      junk = 2'($urandom);
      step(1'b0, 1'b1, junk[0], junk[1], 24'($urandom), 1'b0, 12'd0, 0);
    end
    step(1'b1, 1'b1, hs, vs, d, exp_wr, a, tog ? 3 : 2);
  endtask

  task automatic run_line(input int y, input int len, input bit vs_region,
                          input bit wr, input bit tog);
    for (int x = 0; x < len; x++) begin
      logic        hs, vs, act;
      logic [23:0] d;
      logic [11:0] a;
      int          ly, px;
      hs  = (x < ((len >= 24) ? 4 : 2)) ? 1'b0 : 1'b1;
      vs  = (vs_region && y < 3) ? 1'b0 : 1'b1;
      ly  = y - 3;
      px  = x - 6;
      act = wr && (y >= 3) && (y < 23) && (x >= 6) && (x < 18);
      d   = 24'($urandom);
      a   = {2'(ly), 10'(px)};
      sample(hs, vs, d, act, a, tog);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wren"}, {31'd0, wren}, 32'd0);
    check({tag, "_wraddr"}, {20'd0, wraddr}, 32'd0);
    check({tag, "_wrdata"}, {8'd0, wrdata}, 32'd0);
    check({tag, "_starttrigger"}, {31'd0, starttrigger}, 32'd0);
    check({tag, "_line_doubler"}, {31'd0, line_doubler}, 32'd0);
    check({tag, "_add_line"}, {31'd0, add_line}, 32'd0);
    check({tag, "_field_lines"}, {21'd0, field_lines}, 32'd0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 24'd0, 1'b0, 12'd0, 0);
    q.delete();
    check_zero("reset");
  endtask

  task automatic run_entry(input vec_t v, input int idx);
    if (v.rst) do_reset();
    for (int y = 0; y < v.lines; y++) begin
      run_line(y, v.len, v.vs, v.wr, v.tog);
      if (y == 0) begin
        check($sformatf("v%0d_field_lines", idx), {21'd0, field_lines}, v.fl);
        check($sformatf("v%0d_line_doubler", idx), {31'd0, line_doubler}, {31'd0, v.ld_s});
        check($sformatf("v%0d_add_line", idx), {31'd0, add_line}, {31'd0, v.al_s});
        check($sformatf("v%0d_st_start", idx), {31'd0, starttrigger}, {31'd0, v.st_s});
      end
    end
    check($sformatf("v%0d_line_doubler_end", idx), {31'd0, line_doubler}, {31'd0, v.ld_e});
    check($sformatf("v%0d_add_line_end", idx), {31'd0, add_line}, {31'd0, v.al_e});
    check($sformatf("v%0d_st_end", idx), {31'd0, starttrigger}, {31'd0, v.st_e});
    check($sformatf("v%0d_pending", idx), q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[17];
    //            rst lines len vs tog wr  fl  ld_s al_s st_s ld_e al_e st_e
    // Alternating 14/15-line fields (240p interlaced)
    vec[0]  = '{1, 14,   24, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vec[1]  = '{0, 15,   24, 1, 0, 1, 14, 1, 0, 0, 1, 0, 1};
    vec[2]  = '{0, 14,   24, 1, 0, 0, 15, 1, 1, 0, 1, 1, 0};
    vec[3]  = '{0, 15,   24, 1, 0, 1, 14, 1, 1, 0, 1, 1, 1};
    vec[4]  = '{0, 14,   24, 1, 0, 1, 15, 1, 1, 1, 1, 1, 1};
    vec[5]  = '{0, 15,   24, 1, 0, 1, 14, 1, 1, 1, 1, 1, 1};
    // Sync loss from RUN: vsync stays high, short lines, no vsync
    vec[6]  = '{0, 2100, 6,  0, 0, 0, 14, 1, 1, 1, 0, 0, 0};
    vec[7]  = '{0, 30,   24, 1, 0, 0, 14, 0, 0, 0, 0, 0, 0};
    vec[8]  = '{0, 30,   24, 1, 0, 1, 30, 0, 0, 0, 0, 0, 1};
    // Progressive 30-line fields, then switch to 15-line, then pixel_en toggling
    vec[9]  = '{1, 30,   24, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vec[10] = '{0, 30,   24, 1, 0, 1, 30, 0, 0, 0, 0, 0, 1};
    vec[11] = '{0, 30,   24, 1, 0, 1, 30, 0, 0, 1, 0, 0, 1};
    vec[12] = '{0, 15,   24, 1, 0, 1, 30, 0, 0, 1, 0, 0, 1};
    vec[13] = '{0, 15,   24, 1, 0, 0, 15, 1, 0, 0, 1, 0, 0};
    vec[14] = '{0, 15,   24, 1, 0, 1, 15, 1, 0, 0, 1, 0, 1};
    vec[15] = '{0, 15,   24, 1, 1, 1, 15, 1, 0, 1, 1, 0, 1};
    vec[16] = '{0, 15,   24, 1, 1, 1, 15, 1, 0, 1, 1, 0, 1};

    for (int i = 0; i < 17; i++) run_entry(vec[i], i);

    // Reset in the middle of an active line while in RUN, then no vsync.
    for (int y = 0; y < 8; y++) run_line(y, 24, 1'b1, 1'b1, 1'b0);
    for (int x = 0; x < 10; x++) begin
      logic [23:0] d;
      d = 24'($urandom);
      sample((x < 4) ? 1'b0 : 1'b1, 1'b1, d, (x >= 6), {2'd1, 10'(x - 6)}, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 1'b1, 24'($urandom), 1'b0, 12'd0, 0);
    q.delete();
    step(1'b1, 1'b1, 1'b1, 1'b1, 24'($urandom), 1'b0, 12'd0, 0);
    check_zero("midline_reset");
    for (int x = 12; x < 24; x++) step(1'b1, 1'b1, 1'b1, 1'b1, 24'($urandom), 1'b0, 12'd0, 0);
    for (int y = 9; y < 15; y++) run_line(y, 24, 1'b1, 1'b0, 1'b0);
    for (int y = 0; y < 2100; y++) run_line(y, 6, 1'b0, 1'b0, 1'b0);
    check_zero("hold_idle");

    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 24'd0, 1'b0, 12'd0, 0);
    check("final_pending", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
